// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: wait-stated word SRAM with byte lanes.
// Optional `DMEM_ALIGN_CHECK_EN enables misaligned-access error reporting.
module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [1:0]          lo_q, lo_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [1:0]          size_q, size_d;
   logic                sext_q, sext_d;
   logic                err_q, err_d;

   logic [31:0]         mem [2**ADDR_W];
   logic [31:0]         word_q;

   logic                mis;
   logic [1:0]          lo_in;
   logic                commit;
   logic [3:0]          be;
   logic [31:0]         wlane;
   logic [7:0]          bsel;
   logic [15:0]         hsel;
   logic [31:0]         fmt;
   logic                unused_addr;

   assign unused_addr = ^addr[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
   always_comb begin
      lo_in = addr[1:0];
      case (size)
         2'b00:   mis = 1'b0;
         2'b01:   mis = addr[0];
         default: mis = |addr[1:0];
      endcase
   end
`else
   // Without checking, sub-size address bits are simply ignored.
   always_comb begin
      mis = 1'b0;
      case (size)
         2'b00:   lo_in = addr[1:0];
         2'b01:   lo_in = {addr[1], 1'b0};
         default: lo_in = 2'b00;
      endcase
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      idx_d   = idx_q;
      lo_d    = lo_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      sext_d  = sext_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d    = we;
               idx_d   = addr[ADDR_W+1:2];
               lo_d    = lo_in;
               wdata_d = wdata;
               size_d  = size;
               sext_d  = sign_ext;
               err_d   = mis;
               cnt_d   = CNT_INIT;
               state_d = mis ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         lo_q    <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         sext_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         err_q   <= err_d;
      end
   end

   assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);

   always_comb begin
      be    = 4'b1111;
      wlane = wdata_q;
      case (size_q)
         2'b00: begin
            be    = 4'b0001 << lo_q;
            wlane = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be    = lo_q[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   // SRAM array and read register carry no reset.
   always_ff @(posedge clk) begin
      if (commit) begin
         if (we_q) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) mem[idx_q][8*i +: 8] <= wlane[8*i +: 8];
         end else begin
            word_q <= mem[idx_q];
         end
      end
   end

   always_comb begin
      case (lo_q)
         2'd0:    bsel = word_q[7:0];
         2'd1:    bsel = word_q[15:8];
         2'd2:    bsel = word_q[23:16];
         default: bsel = word_q[31:24];
      endcase
      hsel = lo_q[1] ? word_q[31:16] : word_q[15:0];
      case (size_q)
         2'b00:   fmt = {{24{sext_q & bsel[7]}}, bsel};
         2'b01:   fmt = {{16{sext_q & hsel[15]}}, hsel};
         default: fmt = word_q;
      endcase
   end

   assign done  = (state_q == S_RESP);
   assign err   = done & err_q;
   assign rdata = (done && !we_q && !err_q) ? fmt : 32'd0;
   assign stall = !rst && ((state_q == S_WAIT) ||
                           ((state_q == S_IDLE) && req));

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus scoreboard
// queue, with hand sequences for reset-in-WAIT and held-req streaming.
module tb_dmem_responder;

   localparam int W = 2;
`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_stall;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic        er;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  size = '0;
   logic        sign_ext = 1'b0;
   logic [31:0] rdata;
   logic        stall;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;
   resp_t exp_q[$];
   vec_t  vecs[15];

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .size(size), .sign_ext(sign_ext),
      .rdata(rdata), .stall(stall), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] s,
                               input logic se, input logic [31:0] r,
                               input logic e, input int st);
      vec_t v;
      v.we = w; v.addr = a; v.wdata = d; v.size = s; v.sext = se;
      v.exp_rd = r; v.exp_err = e; v.exp_stall = st;
      return v;
   endfunction

   task automatic run(input vec_t v, input string nm);
      resp_t r;
      int    st;
      bit    got;
      @(negedge clk);
      we = v.we; addr = v.addr; wdata = v.wdata;
      size = v.size; sign_ext = v.sext; req = 1'b1;
      exp_q.push_back('{rd: v.exp_rd, er: v.exp_err});
      #1;
      st = 0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         if (done) begin
            got = 1'b1;
            req = 1'b0;
            r = exp_q.pop_front();
            chk({nm, ".rdata"}, rdata, r.rd);
            chk({nm, ".err"}, {31'd0, err}, {31'd0, r.er});
            chk({nm, ".stall_cycles"}, st, v.exp_stall);
            chk({nm, ".stall_at_done"}, {31'd0, stall}, 32'd0);
         end else begin
            if (stall) st++;
            @(negedge clk);
            #1;
         end
      end
      if (!got) begin
         errors++;
         checks++;
         req = 1'b0;
         void'(exp_q.pop_front());
         $display("FAIL %s.timeout: got no done expected done", nm);
      end
   endtask

   logic [31:0] w10;
   logic [31:0] seq_addr [4];
   logic [31:0] seq_exp [4];

   initial begin
      w10 = CHK ? 32'h80ADBEEF : 32'h80AD5A5A;
      vecs[0]  = mk(1, 32'h10, 32'hDEADBEEF, 2, 0, 0, 0, W+1);
      vecs[1]  = mk(0, 32'h10, 0, 2, 0, 32'hDEADBEEF, 0, W+1);
      vecs[2]  = mk(1, 32'h13, 32'h12345680, 0, 0, 0, 0, W+1);
      vecs[3]  = mk(0, 32'h10, 0, 2, 0, 32'h80ADBEEF, 0, W+1);
      vecs[4]  = mk(0, 32'h13, 0, 0, 1, 32'hFFFFFF80, 0, W+1);
      vecs[5]  = mk(0, 32'h13, 0, 0, 0, 32'h00000080, 0, W+1);
      vecs[6]  = mk(0, 32'h12, 0, 1, 1, 32'hFFFF80AD, 0, W+1);
      vecs[7]  = mk(1, 32'h11, 32'hAAAA5A5A, 1, 0, 0, CHK,
                    CHK ? 1 : W+1);
      vecs[8]  = mk(0, 32'h10, 0, 3, 0, w10, 0, W+1);
      vecs[9]  = mk(0, 32'h12, 0, 2, 0, CHK ? 32'd0 : w10, CHK,
                    CHK ? 1 : W+1);
      vecs[10] = mk(0, 32'h10, 0, 1, 0,
                    CHK ? 32'h0000BEEF : 32'h00005A5A, 0, W+1);
      vecs[11] = mk(0, 32'h12, 0, 0, 1, 32'hFFFFFFAD, 0, W+1);
      vecs[12] = mk(1, 32'h1000, 32'hCAFEF00D, 2, 0, 0, 0, W+1);
      vecs[13] = mk(0, 32'h0, 0, 2, 0, 32'hCAFEF00D, 0, W+1);
      vecs[14] = mk(0, 32'h2, 0, 1, 1, 32'hFFFFCAFE, 0, W+1);

      // reset state, including req high while in reset
      #3;
      chk("rst.rdata", rdata, 0);
      chk("rst.done", {31'd0, done}, 0);
      chk("rst.err", {31'd0, err}, 0);
      req = 1'b1;
      #1;
      chk("rst.stall_req", {31'd0, stall}, 0);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++)
         run(vecs[i], $sformatf("vec%0d", i));

      // reset during WAIT drops the pending store
      run(mk(1, 32'h20, 32'h11111111, 2, 0, 0, 0, W+1), "pre20");
      @(negedge clk);
      we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
      size = 2; req = 1'b1;
      @(negedge clk);
      #1;
      chk("wait.stall", {31'd0, stall}, 1);
      rst = 1'b1;
      #1;
      chk("rstw.stall", {31'd0, stall}, 0);
      chk("rstw.done", {31'd0, done}, 0);
      chk("rstw.rdata", rdata, 0);
      chk("rstw.err", {31'd0, err}, 0);
      @(negedge clk);
      req = 1'b0;
      rst = 1'b0;
      run(mk(0, 32'h20, 0, 2, 0, 32'h11111111, 0, W+1), "post20");

      // four loads with req held high throughout
      seq_addr[0] = 32'h0;    seq_exp[0] = 32'hCAFEF00D;
      seq_addr[1] = 32'h20;   seq_exp[1] = 32'h11111111;
      seq_addr[2] = 32'h1000; seq_exp[2] = 32'hCAFEF00D;
      seq_addr[3] = 32'h1020; seq_exp[3] = 32'h11111111;
      begin
         int ndone;
         int last;
         resp_t r;
         ndone = 0;
         last = 0;
         @(negedge clk);
         we = 1'b0; size = 2; sign_ext = 1'b0;
         addr = seq_addr[0]; req = 1'b1;
         exp_q.push_back('{rd: seq_exp[0], er: 1'b0});
         #1;
         for (int c = 0; c < 40; c++) begin
            if (done) begin
               if (exp_q.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL b2b.extra: got done expected none");
               end else begin
                  r = exp_q.pop_front();
                  chk($sformatf("b2b%0d.rdata", ndone), rdata, r.rd);
               end
               if (ndone > 0)
                  chk($sformatf("b2b%0d.spacing", ndone), c - last, W+2);
               last = c;
               ndone++;
               if (ndone < 4) begin
                  addr = seq_addr[ndone];
                  exp_q.push_back('{rd: seq_exp[ndone], er: 1'b0});
               end else begin
                  req = 1'b0;
               end
            end
            @(negedge clk);
            #1;
         end
         chk("b2b.count", ndone, 4);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
